// File: rtl/uart_transceiver.sv
// Full-duplex 8-bit UART with even parity: independent transmit and receive engines on one clock.
// Frame: start(0), d0..d7 LSB first, even parity, stop(1); each bit lasts CLKS_PER_BIT clocks.
module uart_transceiver #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s1,
  input  logic       s0,
  input  logic       run,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       tx,
  input  logic       rx,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Modes 01/10 enable the transmitter, 01/11 enable the receiver.
  logic tx_en;
  logic rx_en;
  assign tx_en = s1 ^ s0;
  assign rx_en = s0;

  state_t          tx_state_q;
  logic [CW-1:0]   tx_cnt_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_shift_q;
  logic            tx_par_q;
  logic            tx_q;
  logic            run_q;
  logic            run_prev_q;
  logic            run_rise;

  assign run_rise = run_q & ~run_prev_q;

  // Transmit engine: run edge detection, frame sequencing and registered tx line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      run_q      <= 1'b0;
      run_prev_q <= 1'b0;
    end else begin
      run_q      <= run;
      run_prev_q <= run_q;
      case (tx_state_q)
        S_IDLE: begin
          tx_q     <= 1'b1;
          tx_cnt_q <= '0;
          tx_bit_q <= 3'd0;
          if (run_rise && tx_en) begin
            tx_shift_q <= din;
            tx_par_q   <= even_par(din);
            tx_q       <= 1'b0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_bit_q   <= 3'd0;
              tx_q       <= tx_par_q;
              tx_state_q <= S_PARITY;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_q       <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            tx_state_q <= S_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= S_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
          tx_q <= 1'b1;
        end
        default: begin
          tx_state_q <= S_IDLE;
          tx_cnt_q   <= '0;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;
  logic rx_fall;

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // Two-flop synchroniser for the asynchronous rx line plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  state_t          rx_state_q;
  logic [CW-1:0]   rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_shift_q;
  logic            rx_par_q;
  logic [7:0]      dout_q;
  logic            done_q;
  logic            err_q;

  // Receive engine: mid-bit sampling; the start bit is re-checked at its midpoint to reject glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_par_q   <= 1'b0;
      dout_q     <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          rx_bit_q <= 3'd0;
          if (rx_en && rx_fall) begin
            rx_state_q <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            if (!rx_sync_q) begin
              err_q      <= 1'b0;
              rx_state_q <= S_DATA;
            end else begin
              rx_state_q <= S_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_bit_q   <= 3'd0;
              rx_state_q <= S_PARITY;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rx_sync_q;
            rx_state_q <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            dout_q     <= rx_shift_q;
            done_q     <= 1'b1;
            err_q      <= (even_par(rx_shift_q) ^ rx_par_q) | ~rx_sync_q;
            rx_state_q <= S_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin
          rx_state_q <= S_IDLE;
          rx_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign dout = dout_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: two cross-connected instances; u1's rx can be taken over by the bench.
// Expected frames and results come from the frame rules (start, LSB-first data, even parity, stop).
module tb_uart_transceiver;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       s1_1, s0_1, run1, run2;
  logic [7:0] din1, din2;
  logic [7:0] u1_dout, u2_dout;
  logic       u1_tx, u2_tx, u1_done, u2_done, u1_err, u2_err;
  logic       bench_rx, use_bench, u1_rx;
  logic       u2_s1, u2_s0;

  int n_cmp;
  int n_bad;
  int tx1_low;
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  assign u1_rx = use_bench ? bench_rx : u2_tx;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) u1 (
    .clk(clk), .rst_n(rst_n), .s1(s1_1), .s0(s0_1), .run(run1), .din(din1),
    .dout(u1_dout), .tx(u1_tx), .rx(u1_rx), .done(u1_done), .err(u1_err)
  );

  uart_transceiver #(.CLKS_PER_BIT(CPB)) u2 (
    .clk(clk), .rst_n(rst_n), .s1(u2_s1), .s0(u2_s0), .run(run2), .din(din2),
    .dout(u2_dout), .tx(u2_tx), .rx(u1_tx), .done(u2_done), .err(u2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every received frame result and count low cycles on u1's tx.
  always @(negedge clk) begin
    if (u1_done) q1.push_back({u1_err, u1_dout});
    if (u2_done) q2.push_back({u2_err, u2_dout});
    if (!u1_tx) tx1_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rx(input string tag, input int which, input logic [7:0] d, input logic e);
    logic [8:0] got;
    int sz;
    sz = (which == 1) ? q1.size() : q2.size();
    chk({tag, "_cnt"}, sz, 1);
    if (sz > 0) begin
      got = (which == 1) ? q1.pop_front() : q2.pop_front();
      chk({tag, "_dout"}, got[7:0], d);
      chk({tag, "_err"}, got[8], e);
    end
  endtask

  // Send d from u1 and check the full line waveform cycle by cycle.
  task automatic tx_frame(input logic [7:0] d);
    logic [10:0] bits;
    int waited;
    int bad;
    bits = {1'b1, ^d, d, 1'b0};
    din1 = d;
    run1 = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (u1_tx && waited < 4 * CPB);
    chk("tx_lat", waited, 2);
    for (int k = 0; k < 11; k++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (u1_tx !== bits[k]) bad++;
        @(negedge clk);
      end
      if (k == 0) din1 = ~d;
      chk($sformatf("tx_bit%0d", k), bad, 0);
    end
    bad = 0;
    for (int c = 0; c < 3 * CPB; c++) begin
      if (u1_tx !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("tx_rerun", bad, 0);
    run1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Drive one frame onto u1's rx; err_mid samples err once the start bit is accepted.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stopb,
                            output logic err_mid);
    logic [10:0] bits;
    bits = {stopb, (^d) ^ flip, d, 1'b0};
    err_mid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      bench_rx = bits[k];
      for (int c = 0; c < CPB; c++) begin
        if (k == 2 && c == 0) err_mid = u1_err;
        @(negedge clk);
      end
    end
    bench_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       em, flip, stopb;
    logic [7:0] last1;
    int         lows;
    n_cmp = 0; n_bad = 0; tx1_low = 0;
    rst_n = 1'b0; s1_1 = 1'b0; s0_1 = 1'b1; u2_s1 = 1'b0; u2_s0 = 1'b1;
    run1 = 1'b0; run2 = 1'b0; din1 = 8'h00; din2 = 8'h00;
    bench_rx = 1'b1; use_bench = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", u1_tx, 1'b1);
    chk("rst_dout", u1_dout, 8'h00);
    chk("rst_done", u1_done, 1'b0);
    chk("rst_err", u1_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Cross-connected full duplex exchange
    din1 = 8'h78; din2 = 8'hF0; run1 = 1'b1; run2 = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    expect_rx("dup1_u1", 1, 8'hF0, 1'b0);
    expect_rx("dup1_u2", 2, 8'h78, 1'b0);
    run1 = 1'b0; run2 = 1'b0;
    repeat (4) @(negedge clk);
    din1 = 8'h16; din2 = 8'h2C; run1 = 1'b1; run2 = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    expect_rx("dup2_u1", 1, 8'h2C, 1'b0);
    expect_rx("dup2_u2", 2, 8'h16, 1'b0);
    run1 = 1'b0; run2 = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    q1.delete(); q2.delete();

    // Transmit waveform: fixed pattern then random bytes
    tx_frame(8'hA5);
    expect_rx("txA5_u2", 2, 8'hA5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      tx_frame(d);
      expect_rx("txrnd_u2", 2, d, 1'b0);
    end
    q1.delete();

    // Receive path with error injection
    use_bench = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b1, em);
    expect_rx("par_err", 1, 8'h3C, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1, em);
    chk("err_clear", em, 1'b0);
    expect_rx("good01", 1, 8'h01, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, em);
    expect_rx("stop_err", 1, 8'h5A, 1'b1);
    last1 = 8'h5A;
    bench_rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    bench_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_cnt", q1.size(), 0);
    chk("glitch_dout", u1_dout, last1);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      flip = ($urandom_range(3) == 0);
      stopb = ($urandom_range(3) != 0);
      send_frame(d, flip, stopb, em);
      chk("rnd_errmid", em, 1'b0);
      expect_rx("rnd_rx", 1, d, flip | ~stopb);
      last1 = d;
    end

    // Modes: 00 disabled, 11 receive only, 10 transmit only
    s1_1 = 1'b0; s0_1 = 1'b0;
    lows = tx1_low;
    run1 = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b1, em);
    chk("m00_tx", tx1_low - lows, 0);
    chk("m00_rx", q1.size(), 0);
    run1 = 1'b0;
    repeat (4) @(negedge clk);
    s1_1 = 1'b1; s0_1 = 1'b1;
    lows = tx1_low;
    run1 = 1'b1;
    d = 8'($urandom);
    send_frame(d, 1'b0, 1'b1, em);
    chk("m11_tx", tx1_low - lows, 0);
    expect_rx("m11_rx", 1, d, 1'b0);
    last1 = d;
    run1 = 1'b0;
    repeat (4) @(negedge clk);
    s1_1 = 1'b1; s0_1 = 1'b0;
    send_frame(8'h99, 1'b0, 1'b1, em);
    chk("m10_rx", q1.size(), 0);
    chk("m10_dout", u1_dout, last1);
    s1_1 = 1'b0; s0_1 = 1'b1;
    repeat (4) @(negedge clk);

    // Reset mid-frame after an errored frame
    send_frame(8'h3C, 1'b1, 1'b1, em);
    expect_rx("pre_rst", 1, 8'h3C, 1'b1);
    use_bench = 1'b0;
    din1 = 8'hE7; run1 = 1'b1;
    repeat (3 * CPB + 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_tx", u1_tx, 1'b1);
    chk("mrst_dout", u1_dout, 8'h00);
    chk("mrst_done", u1_done, 1'b0);
    chk("mrst_err", u1_err, 1'b0);
    @(negedge clk);
    run1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    q1.delete(); q2.delete();
    d = 8'($urandom);
    tx_frame(d);
    expect_rx("post_rst", 2, d, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
